// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first, and
// registers sum, carry-out and signed overflow once the last digit is done.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]       dig_res;
    logic                 msb_cin;
    logic [WIDTH+DIGIT-1:0] part_cat;
    logic [WIDTH-1:0]     part_next;
    logic                 last_dig;

    // Operands shift right each RUN cycle, so the active digit is always at the bottom.
    assign dig_res   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign msb_cin   = dig_res[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    assign part_cat  = {dig_res[DIGIT-1:0], part_q};
    assign part_next = part_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_dig  = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    part_d  = '0;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                part_d  = part_next;
                carry_d = dig_res[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last_dig) begin
                    state_d = StDone;
                    sum_d   = part_next;
                    cout_d  = dig_res[DIGIT];
                    ovf_d   = msb_cin ^ dig_res[DIGIT];
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: fixed vectors, exhaustive 4-bit sweep,
// random 8-bit ops against an arithmetic model, reset/start disturbance and hold.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        res_t       exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 8-bit group: [0] DIGIT=1, [1] DIGIT=4
    logic       start8 [2];
    logic       sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8 [2], done8 [2], cout8 [2], ovf8 [2];
    logic [7:0] sum8 [2];

    // 4-bit group: [0] DIGIT=1, [1] DIGIT=2, [2] DIGIT=4
    logic       start4 [3];
    logic       sub4, cin4;
    logic [3:0] a4, b4;
    logic       busy4 [3], done4 [3], cout4 [3], ovf4 [3];
    logic [3:0] sum4 [3];

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start8[0]), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8[0]), .done(done8[0]), .sum(sum8[0]), .cout(cout8[0]), .ovf(ovf8[0]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(start8[1]), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8[1]), .done(done8[1]), .sum(sum8[1]), .cout(cout8[1]), .ovf(ovf8[1]));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .start(start4[0]), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]), .cout(cout4[0]), .ovf(ovf4[0]));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(start4[1]), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]), .cout(cout4[1]), .ovf(ovf4[1]));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
        .clk(clk), .rst(rst), .start(start4[2]), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]), .cout(cout4[2]), .ovf(ovf4[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow from the signed-range rule.
    function automatic res_t model(input int w, input int unsigned a, input int unsigned b,
                                   input bit cin, input bit sub);
        int unsigned mask, bb, full, seed;
        int          sa, sb, s, lim;
        res_t        r;
        mask   = (32'd1 << w) - 1;
        bb     = sub ? (~b & mask) : (b & mask);
        seed   = sub ? 1 : (cin ? 1 : 0);
        full   = a + bb + seed;
        lim    = 1 << (w - 1);
        sa     = (a >= lim) ? int'(a) - 2 * lim : int'(a);
        sb     = (bb >= lim) ? int'(bb) - 2 * lim : int'(bb);
        s      = sa + sb + int'(seed);
        r.sum  = 8'(full & mask);
        r.cout = ((full >> w) & 1) != 0;
        r.ovf  = (s >= lim) || (s < -lim);
        return r;
    endfunction

    function automatic int ndig8(input int idx);
        return (idx == 0) ? 8 : 2;
    endfunction

    // One 8-bit op; operands are scrambled after E0, and optionally start is
    // re-pulsed with new operands 'poke' cycles into RUN.
    task automatic run_op8(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input int poke,
                           output res_t r, output int lat, output int bc);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub;
        start8[idx] = 1'b1;
        @(posedge clk); #1;
        start8[idx] = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        lat = 0;
        bc = 0;
        while (lat < 40 && !done8[idx]) begin
            if (busy8[idx]) bc++;
            if (lat == poke) begin
                start8[idx] = 1'b1;
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            end
            if (lat == poke + 1) start8[idx] = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = {sum8[idx], cout8[idx], ovf8[idx]};
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done8[idx]), 32'd0);
    endtask

    vec_t vecs [8];
    res_t r, exp_r, r4 [3];
    int   lat, bc, n, saw, cyc, lat4 [3];
    int   dc [$];

    initial begin
        vecs[0] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1}};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0}};
        vecs[2] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, {8'h01, 1'b0, 1'b0}};
        vecs[3] = '{1, 8'h05, 8'h07, 1'b0, 1'b1, {8'hFE, 1'b0, 1'b0}};
        vecs[4] = '{1, 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1}};
        vecs[5] = '{0, 8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0}};
        vecs[6] = '{1, 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1}};
        vecs[7] = '{1, 8'h00, 8'h00, 1'b1, 1'b1, {8'h00, 1'b1, 1'b0}};

        rst = 1'b1;
        start8 = '{1'b0, 1'b0};
        start4 = '{1'b0, 1'b0, 1'b0};
        a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy8[0]), 32'd0);
        check("reset_done", 32'(done8[0]), 32'd0);
        check("reset_res8", 32'({sum8[0], cout8[0], ovf8[0]}), 32'd0);
        check("reset_res4", 32'({sum4[2], cout4[2], ovf4[2]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op8(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, -1, r, lat, bc);
            check($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].exp));
            check($sformatf("vec%0d_lat", i), lat, ndig8(vecs[i].idx));
            check($sformatf("vec%0d_busy", i), bc, ndig8(vecs[i].idx));
        end

        // Exhaustive 4-bit sweep on all three digit widths at once
        for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
        for (int si = 0; si < 2; si++) begin
            @(negedge clk);
            a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); sub4 = 1'(si);
            start4 = '{1'b1, 1'b1, 1'b1};
            @(posedge clk); #1;
            start4 = '{1'b0, 1'b0, 1'b0};
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
            lat4 = '{-1, -1, -1};
            r4 = '{'1, '1, '1};
            n = 0;
            forever begin
                for (int k = 0; k < 3; k++) begin
                    if (done4[k] && lat4[k] < 0) begin
                        lat4[k] = n;
                        r4[k] = {4'b0, sum4[k], cout4[k], ovf4[k]};
                    end
                end
                if ((lat4[0] >= 0 && lat4[1] >= 0 && lat4[2] >= 0) || n >= 12) break;
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            exp_r = model(4, ai, bi, 1'(ci), 1'(si));
            for (int k = 0; k < 3; k++) begin
                check($sformatf("sweep_d%0d_res a=%0h b=%0h c=%0d s=%0d", 1 << k, ai, bi, ci, si),
                      32'(r4[k]), 32'(exp_r));
                check($sformatf("sweep_d%0d_lat", 1 << k), lat4[k], 4 >> k);
            end
        end

        repeat (30) begin
            automatic int         idx = int'($urandom_range(0, 1));
            automatic logic [7:0] ra = 8'($urandom);
            automatic logic [7:0] rb = 8'($urandom);
            automatic logic       rc = 1'($urandom);
            automatic logic       rs = 1'($urandom);
            run_op8(idx, ra, rb, rc, rs, -1, r, lat, bc);
            check($sformatf("rand_res a=%0h b=%0h c=%0d s=%0d", ra, rb, rc, rs),
                  32'(r), 32'(model(8, ra, rb, rc, rs)));
            check("rand_lat", lat, ndig8(idx));
        end

        // Start pulsed mid-RUN with new operands must be ignored
        run_op8(0, 8'h12, 8'h34, 1'b0, 1'b0, 2, r, lat, bc);
        check("poke_res", 32'(r), 32'({8'h46, 1'b0, 1'b0}));
        check("poke_lat", lat, 8);
        saw = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy8[0] || done8[0]) saw = 1;
        end
        check("poke_not_queued", saw, 0);

        // Hold: idle input churn must not disturb registered results
        run_op8(0, 8'h7F, 8'h01, 1'b0, 1'b0, -1, r, lat, bc);
        check("hold_pre", 32'(r), 32'({8'h80, 1'b0, 1'b1}));
        repeat (5) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            check("hold_res", 32'({sum8[0], cout8[0], ovf8[0]}), 32'({8'h80, 1'b0, 1'b1}));
        end

        // Reset in the 3rd RUN cycle aborts with immediate clear
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0;
        start8[0] = 1'b1;
        @(posedge clk); #1;
        start8[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("abort_busy_before", 32'(busy8[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy8[0]), 32'd0);
        check("abort_done", 32'(done8[0]), 32'd0);
        check("abort_res", 32'({sum8[0], cout8[0], ovf8[0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8[0] || busy8[0]) saw = 1;
        end
        check("abort_no_done", saw, 0);
        run_op8(0, 8'hA5, 8'h5A, 1'b1, 1'b0, -1, r, lat, bc);
        check("post_reset_res", 32'(r), 32'({8'h00, 1'b1, 1'b0}));
        check("post_reset_lat", lat, 8);

        // Start held high: three back-to-back ops, done every NDIG+2 cycles
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0;
        start8[0] = 1'b1;
        cyc = 0;
        while (dc.size() < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done8[0]) begin
                dc.push_back(cyc);
                check("b2b_res", 32'({sum8[0], cout8[0], ovf8[0]}), 32'({8'h33, 1'b0, 1'b0}));
            end
        end
        start8[0] = 1'b0;
        check("b2b_count", dc.size(), 3);
        if (dc.size() == 3) begin
            check("b2b_first", dc[0], 9);
            check("b2b_gap1", dc[1] - dc[0], 10);
            check("b2b_gap2", dc[2] - dc[1], 10);
        end
        saw = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy8[0]) saw = 1;
        end
        check("b2b_stop", saw, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
